// File: rtl/psram_user_port_responder.sv
// psram_user_port_responder: BRAM-backed stand-in for the PSRAM controller
// user port. It models the calibration delay, masked burst writes, a fixed
// read latency and the minimum spacing between accepted commands.
module psram_user_port_responder #(
  parameter int MEM_AW      = 10,
  parameter int BURST       = 4,
  parameter int RD_LATENCY  = 6,
  parameter int CMD_GAP     = 14,
  parameter int INIT_CYCLES = 64
) (
  input  logic        clk_out,
  input  logic        rst_n,
  output logic        init_calib,
  input  logic        cmd,
  input  logic        cmd_en,
  input  logic [20:0] addr,
  input  logic [31:0] wr_data,
  input  logic [3:0]  data_mask,
  output logic [31:0] rd_data,
  output logic        rd_data_valid,
  output logic        cmd_err
);

  localparam int DEPTH = 1 << MEM_AW;
  localparam int BW    = $clog2(BURST + 1);
  localparam int GW    = $clog2(CMD_GAP + 1);
  localparam int IW    = $clog2(INIT_CYCLES + 1);

  localparam logic [2:0] ST_INIT     = 3'd0;
  localparam logic [2:0] ST_IDLE     = 3'd1;
  localparam logic [2:0] ST_WRITE    = 3'd2;
  localparam logic [2:0] ST_RD_WAIT  = 3'd3;
  localparam logic [2:0] ST_RD_BURST = 3'd4;
  localparam logic [2:0] ST_GAP      = 3'd5;

  logic [31:0]       mem [0:DEPTH-1];

  logic [2:0]        state_q, state_d;
  logic [IW-1:0]     init_cnt_q, init_cnt_d;
  logic              init_calib_q, init_calib_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic [MEM_AW-1:0] base_q, base_d;
  logic [31:0]       rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              cmd_err_q, cmd_err_d;

  logic              ready;
  logic [MEM_AW-1:0] beat_addr;
  logic [2:0]        after_burst;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_waddr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_wmask;
  logic              unused_addr;

  assign unused_addr   = ^addr[20:MEM_AW];
  assign ready         = (state_q == ST_IDLE) && init_calib_q;
  assign beat_addr     = base_q + MEM_AW'(beat_q);
  assign init_calib    = init_calib_q;
  assign rd_data       = rd_data_q;
  assign rd_data_valid = rd_valid_q;
  assign cmd_err       = cmd_err_q;

  // Next-state, beat sequencing, memory write strobes and read capture
  always_comb begin
    state_d      = state_q;
    init_cnt_d   = init_cnt_q;
    init_calib_d = init_calib_q;
    gap_d        = gap_q;
    beat_d       = beat_q;
    base_d       = base_q;
    rd_data_d    = rd_data_q;
    rd_valid_d   = 1'b0;
    cmd_err_d    = cmd_err_q;
    mem_we       = 1'b0;
    mem_waddr    = beat_addr;
    mem_wdata    = wr_data;
    mem_wmask    = data_mask;

    if (cmd_en && !ready) cmd_err_d = 1'b1;

    // gap_q holds the number of cycles elapsed since the accepted command
    if (state_q != ST_IDLE && state_q != ST_INIT) gap_d = gap_q + GW'(1);
    // a burst that ends exactly at the gap limit skips GAP entirely
    after_burst = (gap_d >= GW'(CMD_GAP)) ? ST_IDLE : ST_GAP;

    case (state_q)
      ST_INIT: begin
        init_cnt_d = init_cnt_q + IW'(1);
        if (init_cnt_q == IW'(INIT_CYCLES - 1)) begin
          init_calib_d = 1'b1;
          state_d      = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (cmd_en && init_calib_q) begin
          base_d = addr[MEM_AW-1:0];
          gap_d  = GW'(1);
          if (cmd) begin
            mem_we    = 1'b1;
            mem_waddr = addr[MEM_AW-1:0];
            beat_d    = BW'(1);
            state_d   = ST_WRITE;
          end else begin
            beat_d  = '0;
            state_d = ST_RD_WAIT;
          end
        end
      end
      ST_WRITE: begin
        mem_we = 1'b1;
        if (beat_q == BW'(BURST - 1)) state_d = after_burst;
        else beat_d = beat_q + BW'(1);
      end
      ST_RD_WAIT: begin
        if (gap_q == GW'(RD_LATENCY - 1)) begin
          rd_data_d  = mem[beat_addr];
          rd_valid_d = 1'b1;
          beat_d     = BW'(1);
          state_d    = ST_RD_BURST;
        end
      end
      ST_RD_BURST: begin
        if (beat_q == BW'(BURST)) begin
          state_d = after_burst;
        end else begin
          rd_data_d  = mem[beat_addr];
          rd_valid_d = 1'b1;
          beat_d     = beat_q + BW'(1);
        end
      end
      ST_GAP: begin
        if (gap_d >= GW'(CMD_GAP)) state_d = ST_IDLE;
      end
      default: state_d = ST_INIT;
    endcase
  end

  // Control and output registers, cleared asynchronously
  always_ff @(posedge clk_out or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_INIT;
      init_cnt_q   <= '0;
      init_calib_q <= 1'b0;
      gap_q        <= '0;
      beat_q       <= '0;
      base_q       <= '0;
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
      cmd_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      init_cnt_q   <= init_cnt_d;
      init_calib_q <= init_calib_d;
      gap_q        <= gap_d;
      beat_q       <= beat_d;
      base_q       <= base_d;
      rd_data_q    <= rd_data_d;
      rd_valid_q   <= rd_valid_d;
      cmd_err_q    <= cmd_err_d;
    end
  end

  // Byte-masked memory write; contents survive reset
  always_ff @(posedge clk_out) begin
    if (mem_we) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (!mem_wmask[b]) mem[mem_waddr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_psram_user_port_responder.sv
// Directed bench for psram_user_port_responder: calibration timing, masked
// burst writes, read latency/beats, address wrap, early commands, reset abort.
module tb_psram_user_port_responder;

  logic        clk_out = 1'b0;
  logic        rst_n;
  logic        init_calib;
  logic        cmd;
  logic        cmd_en;
  logic [20:0] addr;
  logic [31:0] wr_data;
  logic [3:0]  data_mask;
  logic [31:0] rd_data;
  logic        rd_data_valid;
  logic        cmd_err;

  int n_vec = 0;
  int n_err = 0;

  psram_user_port_responder #(
    .MEM_AW(10), .BURST(4), .RD_LATENCY(6), .CMD_GAP(14), .INIT_CYCLES(64)
  ) dut (
    .clk_out(clk_out), .rst_n(rst_n), .init_calib(init_calib),
    .cmd(cmd), .cmd_en(cmd_en), .addr(addr), .wr_data(wr_data),
    .data_mask(data_mask), .rd_data(rd_data), .rd_data_valid(rd_data_valid),
    .cmd_err(cmd_err)
  );

  always #5 clk_out = ~clk_out;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called mid-cycle T; returns mid-cycle T+14 (earliest next command).
  task automatic do_write(input logic [20:0] a,
                          input logic [31:0] d0, input logic [31:0] d1,
                          input logic [31:0] d2, input logic [31:0] d3,
                          input logic [3:0] m0, input logic [3:0] m1,
                          input logic [3:0] m2, input logic [3:0] m3);
    cmd_en = 1'b1; cmd = 1'b1; addr = a; wr_data = d0; data_mask = m0;
    @(negedge clk_out);
    cmd_en = 1'b0; cmd = 1'b0; addr = 21'h15555; wr_data = d1; data_mask = m1;
    @(negedge clk_out);
    wr_data = d2; data_mask = m2;
    @(negedge clk_out);
    wr_data = d3; data_mask = m3;
    @(negedge clk_out);
    wr_data = 32'hFFFF_FFFF; data_mask = 4'hF;
    repeat (10) @(negedge clk_out);
  endtask

  // Called mid-cycle T; checks latency, beat count, data and hold value.
  task automatic do_read(input string tag, input logic [20:0] a,
                         input logic [31:0] e0, input logic [31:0] e1,
                         input logic [31:0] e2, input logic [31:0] e3,
                         input bit early);
    logic [31:0] got [4];
    int nv;
    int first;
    nv = 0;
    first = -1;
    for (int i = 0; i < 4; i++) got[i] = 32'h0;
    cmd_en = 1'b1; cmd = 1'b0; addr = a;
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk_out);
      cmd_en = 1'b0;
      if (early && c == 5) begin
        cmd_en = 1'b1; cmd = 1'b1; addr = a; wr_data = 32'hDEAD_BEEF; data_mask = 4'h0;
      end
      if (rd_data_valid) begin
        if (first < 0) first = c;
        if (nv < 4) got[nv] = rd_data;
        nv++;
      end
    end
    chk({tag, "_first_valid"}, first, 32'd6);
    chk({tag, "_nbeats"}, nv, 32'd4);
    chk({tag, "_b0"}, got[0], e0);
    chk({tag, "_b1"}, got[1], e1);
    chk({tag, "_b2"}, got[2], e2);
    chk({tag, "_b3"}, got[3], e3);
    chk({tag, "_hold"}, rd_data, e3);
    @(negedge clk_out);
  endtask

  initial begin
    logic seen;
    rst_n = 1'b0; cmd = 1'b0; cmd_en = 1'b0; addr = '0;
    wr_data = '0; data_mask = 4'hF;

    repeat (3) @(negedge clk_out);
    chk("rst_init_calib", init_calib, 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    chk("rst_rd_valid", rd_data_valid, 32'd0);
    chk("rst_cmd_err", cmd_err, 32'd0);

    // calibration: rises on the 64th edge after release
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 1; c <= 63; c++) begin
      @(negedge clk_out);
      seen = seen | rd_data_valid | cmd_err;
    end
    chk("init_63", init_calib, 32'd0);
    @(negedge clk_out);
    chk("init_64", init_calib, 32'd1);
    chk("init_quiet", seen, 32'd0);

    // known background contents
    do_write(21'h100, 32'h1111_2222, 32'h3333_4444, 32'h5555_6666, 32'h7777_8888,
             4'h0, 4'h0, 4'h0, 4'h0);
    do_write(21'h000, 32'hC0DE_0000, 32'hC0DE_0001, 32'hC0DE_0002, 32'hC0DE_0003,
             4'h0, 4'h0, 4'h0, 4'h0);
    do_write(21'h180, 32'h1234_5678, 32'h0000_0181, 32'h0000_0182, 32'h0000_0183,
             4'h0, 4'h0, 4'h0, 4'h0);

    // partial write: only the upper half of beat 0 lands
    do_write(21'h100, 32'hABCD_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
             4'b0011, 4'hF, 4'hF, 4'hF);
    do_read("rd100", 21'h100, 32'hABCD_2222, 32'h3333_4444, 32'h5555_6666,
            32'h7777_8888, 1'b0);

    // byte lane writes to one word
    do_write(21'h180, 32'h5A00_0000, 32'h0, 32'h0, 32'h0, 4'b0111, 4'hF, 4'hF, 4'hF);
    do_write(21'h180, 32'h00C3_0000, 32'h0, 32'h0, 32'h0, 4'b1011, 4'hF, 4'hF, 4'hF);
    do_read("rd180", 21'h180, 32'h5AC3_5678, 32'h0000_0181, 32'h0000_0182,
            32'h0000_0183, 1'b0);

    // wrap, with high address bits set that must be ignored
    do_write(21'h0FFFFF, 32'd1, 32'd2, 32'd3, 32'd4, 4'h0, 4'h0, 4'h0, 4'h0);
    do_read("rd3ff", 21'h3FF, 32'd1, 32'd2, 32'd3, 32'd4, 1'b0);
    do_read("rd000", 21'h000, 32'd2, 32'd3, 32'd4, 32'hC0DE_0003, 1'b0);

    // early command during a read is dropped and flagged
    chk("err_before_early", cmd_err, 32'd0);
    do_read("early", 21'h100, 32'hABCD_2222, 32'h3333_4444, 32'h5555_6666,
            32'h7777_8888, 1'b1);
    chk("err_after_early", cmd_err, 32'd1);
    do_read("after_early", 21'h100, 32'hABCD_2222, 32'h3333_4444, 32'h5555_6666,
            32'h7777_8888, 1'b0);

    // reset during read beat 1
    cmd_en = 1'b1; cmd = 1'b0; addr = 21'h3FF;
    @(negedge clk_out);
    cmd_en = 1'b0;
    repeat (6) @(negedge clk_out);
    chk("abort_pre_valid", rd_data_valid, 32'd1);
    chk("abort_pre_beat1", rd_data, 32'd2);
    rst_n = 1'b0;
    #1;
    chk("abort_valid", rd_data_valid, 32'd0);
    chk("abort_calib", init_calib, 32'd0);
    chk("abort_rd_data", rd_data, 32'd0);
    repeat (3) @(negedge clk_out);
    rst_n = 1'b1;
    repeat (63) @(negedge clk_out);
    chk("reinit_63", init_calib, 32'd0);
    @(negedge clk_out);
    chk("reinit_64", init_calib, 32'd1);
    chk("reinit_cmd_err", cmd_err, 32'd0);
    do_read("post_rst100", 21'h100, 32'hABCD_2222, 32'h3333_4444, 32'h5555_6666,
            32'h7777_8888, 1'b0);
    do_read("post_rst3ff", 21'h3FF, 32'd1, 32'd2, 32'd3, 32'd4, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
